// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm tone generator.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int unsigned DEF_SAMPLE_W = 32;
  typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

  // Default DAC sample width, tied to the sample_t payload type.
  function automatic int unsigned sample_w();
    return $bits(sample_t);
  endfunction

  localparam logic [0:0] CH_LEFT  = 1'b0;
  localparam logic [0:0] CH_RIGHT = 1'b1;

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Write handshake toward the Audio_Controller DAC FIFO.
interface alarm_tone_gen_if #(
  parameter int unsigned SAMPLE_W = 32
);
  logic                audio_out_allowed;
  logic                write_audio_out;
  logic [SAMPLE_W-1:0] left_channel_audio_out;
  logic [SAMPLE_W-1:0] right_channel_audio_out;

  modport master (
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/sq_osc.sv
// Square-wave oscillator: phase counter and polarity advanced per accepted sample.
module sq_osc #(
  parameter int unsigned SAMPLE_W = 32,
  parameter int unsigned AMP_W    = 24,
  parameter int unsigned HP_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic                       clr,
  input  logic [HP_W-1:0]            i_half_period,
  input  logic [AMP_W-1:0]           i_amplitude,
  output logic signed [SAMPLE_W-1:0] o_sample_nx_c
);

  logic [HP_W-1:0]            r_phase;
  logic                       r_pol;
  logic [HP_W-1:0]            w_hp_last;
  logic                       w_wrap;
  logic                       w_pol_nx;
  logic signed [SAMPLE_W-1:0] w_pos;

  // A half period of 0 behaves as 1: polarity flips on every sample.
  assign w_hp_last = (i_half_period == '0) ? '0 : i_half_period - HP_W'(1);
  assign w_wrap    = (r_phase == w_hp_last);
  assign w_pol_nx  = clr ? 1'b1 : ((adv && w_wrap) ? ~r_pol : r_pol);

  // Sample for the polarity that will hold after this edge.
  assign w_pos         = SAMPLE_W'(i_amplitude);
  assign o_sample_nx_c = w_pol_nx ? w_pos : -w_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_pol   <= 1'b1;
    end else if (clr) begin
      r_phase <= '0;
      r_pol   <= 1'b1;
    end else if (adv) begin
      if (w_wrap) begin
        r_phase <= '0;
        r_pol   <= ~r_pol;
      end else begin
        r_phase <= r_phase + HP_W'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm tone source: cadenced stereo square-wave beeps pushed into the DAC FIFO,
// with pitch and cadence counted in accepted samples rather than clocks.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int unsigned SAMPLE_W = sample_w(),
  parameter int unsigned AMP_W    = 24,
  parameter int unsigned HP_W     = 12,
  parameter int unsigned CAD_W    = 20,
  parameter int unsigned REP_W    = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               enable,
  input  logic [HP_W-1:0]    half_period,
  input  logic [AMP_W-1:0]   amplitude,
  input  logic [CAD_W-1:0]   on_len,
  input  logic [CAD_W-1:0]   off_len,
  input  logic [REP_W-1:0]   repeats,
  input  logic [1:0]         chan_en,
  alarm_tone_gen_if.master   aud,
  output logic               busy,
  output logic               done
);

  state_e              r_state;
  logic                r_en_d;
  logic                r_start;
  logic [HP_W-1:0]     r_hp;
  logic [AMP_W-1:0]    r_amp;
  logic [CAD_W-1:0]    r_on;
  logic [CAD_W-1:0]    r_off;
  logic [REP_W-1:0]    r_rep_cfg;
  logic [1:0]          r_chan;
  logic [CAD_W-1:0]    r_cad;
  logic [REP_W-1:0]    r_rep;
  logic [SAMPLE_W-1:0] r_left;
  logic [SAMPLE_W-1:0] r_right;
  logic                r_busy;
  logic                r_done;

  logic                       w_acc;
  logic                       w_on_last;
  logic                       w_off_last;
  logic [REP_W-1:0]           w_rep_nx;
  logic                       w_rep_end;
  logic                       w_rep_chk;
  logic                       w_osc_adv;
  logic                       w_osc_clr;
  logic signed [SAMPLE_W-1:0] w_samp;
  logic [SAMPLE_W-1:0]        w_left_nx;
  logic [SAMPLE_W-1:0]        w_right_nx;

  assign w_acc      = (r_state != IDLE) && aud.audio_out_allowed;
  assign w_on_last  = (r_cad == r_on - CAD_W'(1));
  assign w_off_last = (r_cad == r_off - CAD_W'(1));
  assign w_rep_nx   = r_rep + REP_W'(1);
  assign w_rep_end  = (r_rep_cfg != '0) && (w_rep_nx == r_rep_cfg);
  assign w_rep_chk  = w_acc && (((r_state == ON) && w_on_last && (r_off == '0)) ||
                                ((r_state == OFF) && w_off_last));

  // Oscillator is held cleared outside ON so every beep starts on the positive half.
  assign w_osc_adv = (r_state == ON) && w_acc;
  assign w_osc_clr = (r_state != ON) || (w_acc && w_on_last);

  sq_osc #(
    .SAMPLE_W (SAMPLE_W),
    .AMP_W    (AMP_W),
    .HP_W     (HP_W)
  ) u_osc (
    .clk           (CLOCK_50),
    .rst_n         (resetn),
    .adv           (w_osc_adv),
    .clr           (w_osc_clr),
    .i_half_period (r_hp),
    .i_amplitude   (r_amp),
    .o_sample_nx_c (w_samp)
  );

  assign w_left_nx  = r_chan[CH_LEFT]  ? w_samp : '0;
  assign w_right_nx = r_chan[CH_RIGHT] ? w_samp : '0;

  assign aud.write_audio_out         = w_acc;
  assign aud.left_channel_audio_out  = r_left;
  assign aud.right_channel_audio_out = r_right;
  assign busy = r_busy;
  assign done = r_done;

  // r_en_d resets high so a level already high at reset release is not a start.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_en_d    <= 1'b1;
      r_start   <= 1'b0;
      r_hp      <= '0;
      r_amp     <= '0;
      r_on      <= '0;
      r_off     <= '0;
      r_rep_cfg <= '0;
      r_chan    <= '0;
      r_cad     <= '0;
      r_rep     <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_en_d  <= enable;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && !r_en_d) begin
            r_start   <= 1'b1;
            r_hp      <= half_period;
            r_amp     <= amplitude;
            r_on      <= on_len;
            r_off     <= off_len;
            r_rep_cfg <= repeats;
            r_chan    <= chan_en;
          end
          if (r_start) begin
            r_cad <= '0;
            r_rep <= '0;
            if (r_on != '0) begin
              r_state <= ON;
              r_busy  <= 1'b1;
              r_left  <= w_left_nx;
              r_right <= w_right_nx;
            end else if (r_off != '0) begin
              r_state <= OFF;
              r_busy  <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          if (!enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
          end else if (w_rep_chk) begin
            r_cad <= '0;
            r_rep <= w_rep_nx;
            if (w_rep_end) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_left  <= '0;
              r_right <= '0;
            end else if (r_on != '0) begin
              r_state <= ON;
              r_left  <= w_left_nx;
              r_right <= w_right_nx;
            end else begin
              r_state <= OFF;
              r_left  <= '0;
              r_right <= '0;
            end
          end else if (w_acc) begin
            if ((r_state == ON) && w_on_last) begin
              r_cad   <= '0;
              r_state <= OFF;
              r_left  <= '0;
              r_right <= '0;
            end else begin
              r_cad <= r_cad + CAD_W'(1);
              if (r_state == ON) begin
                r_left  <= w_left_nx;
                r_right <= w_right_nx;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen: cadence stepping, stalls, continuous mode,
// channel masking, degenerate configs and asynchronous reset.
module tb_alarm_tone_gen;

  localparam int unsigned SW = 32;
  localparam int unsigned AW = 24;
  localparam int unsigned HW = 12;
  localparam int unsigned CW = 20;
  localparam int unsigned RW = 8;

  localparam logic [31:0] P100 = 32'h0000_0064;
  localparam logic [31:0] N100 = 32'hFFFF_FF9C;
  localparam logic [31:0] P5   = 32'h0000_0005;
  localparam logic [31:0] N5   = 32'hFFFF_FFFB;
  localparam logic [31:0] PMAX = 32'h007F_FFFF;
  localparam logic [31:0] NMAX = 32'hFF80_0001;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          enable = 1'b0;
  logic [HW-1:0] half_period = '0;
  logic [AW-1:0] amplitude   = '0;
  logic [CW-1:0] on_len      = '0;
  logic [CW-1:0] off_len     = '0;
  logic [RW-1:0] repeats     = '0;
  logic [1:0]    chan_en     = 2'b11;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_l [64];
  logic [31:0] exp_r [64];
  logic [31:0] step_pat [12];
  logic [31:0] cont_pat [5];

  alarm_tone_gen_if #(.SAMPLE_W(SW)) aud ();

  alarm_tone_gen #(
    .SAMPLE_W (SW),
    .AMP_W    (AW),
    .HP_W     (HW),
    .CAD_W    (CW),
    .REP_W    (RW)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (rst_n),
    .enable      (enable),
    .half_period (half_period),
    .amplitude   (amplitude),
    .on_len      (on_len),
    .off_len     (off_len),
    .repeats     (repeats),
    .chan_en     (chan_en),
    .aud         (aud),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cfg(input logic [HW-1:0] hp, input logic [AW-1:0] amp, input logic [CW-1:0] onl,
                     input logic [CW-1:0] offl, input logic [RW-1:0] rep, input logic [1:0] ch);
    half_period = hp;
    amplitude   = amp;
    on_len      = onl;
    off_len     = offl;
    repeats     = rep;
    chan_en     = ch;
  endtask

  // Raise enable; one cycle later the block must still be idle.
  task automatic start_seq(input string tag);
    @(negedge clk);
    aud.audio_out_allowed = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    #1;
    chk({tag, "_lat_busy"}, 32'(busy), 32'd0);
    chk({tag, "_lat_wr"}, 32'(aud.write_audio_out), 32'd0);
  endtask

  task automatic collect(input string tag, input int n, input bit toggle, input int max_cyc);
    int k = 0;
    for (int c = 0; c < max_cyc && k < n; c++) begin
      @(negedge clk);
      aud.audio_out_allowed = toggle ? ((c % 2) == 0) : 1'b1;
      #1;
      chk({tag, "_wr"}, 32'(aud.write_audio_out), 32'(aud.audio_out_allowed));
      if (aud.write_audio_out) begin
        chk({tag, "_l"}, aud.left_channel_audio_out, exp_l[k]);
        chk({tag, "_r"}, aud.right_channel_audio_out, exp_r[k]);
        k++;
      end
    end
    chk({tag, "_count"}, 32'(k), 32'(n));
  endtask

  task automatic expect_done(input string tag);
    @(negedge clk);
    aud.audio_out_allowed = 1'b1;
    #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    enable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    step_pat = '{P100, P100, N100, N100, P100, P100, N100, N100,
                 32'h0, 32'h0, 32'h0, 32'h0};
    cont_pat = '{P5, N5, P5, 32'h0, 32'h0};
    aud.audio_out_allowed = 1'b1;

    // Reset state
    #1;
    chk("rst_wr", 32'(aud.write_audio_out), 32'd0);
    chk("rst_l", aud.left_channel_audio_out, 32'd0);
    chk("rst_r", aud.right_channel_audio_out, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_wr", 32'(aud.write_audio_out), 32'd0);

    // Stepping
    cfg(12'd2, 24'd100, 20'd8, 20'd4, 8'd1, 2'b11);
    for (int i = 0; i < 12; i++) begin
      exp_l[i] = step_pat[i];
      exp_r[i] = step_pat[i];
    end
    start_seq("step");
    collect("step", 12, 1'b0, 40);
    expect_done("step");

    // Stall: allowed toggles every cycle
    start_seq("stall");
    collect("stall", 12, 1'b1, 60);
    expect_done("stall");

    // Channel mask and sign extension
    cfg(12'd1, 24'h7FFFFF, 20'd4, 20'd0, 8'd1, 2'b10);
    for (int i = 0; i < 4; i++) begin
      exp_l[i] = 32'h0;
      exp_r[i] = ((i % 2) == 0) ? PMAX : NMAX;
    end
    start_seq("chan");
    collect("chan", 4, 1'b0, 20);
    expect_done("chan");

    // half_period 0 toggles every sample
    cfg(12'd0, 24'd100, 20'd3, 20'd1, 8'd1, 2'b11);
    exp_l[0] = P100; exp_l[1] = N100; exp_l[2] = P100; exp_l[3] = 32'h0;
    for (int i = 0; i < 4; i++) exp_r[i] = exp_l[i];
    start_seq("hp0");
    collect("hp0", 4, 1'b0, 20);
    expect_done("hp0");

    // on_len 0 and off_len 0: no writes, done one cycle after start
    cfg(12'd1, 24'd100, 20'd0, 20'd0, 8'd0, 2'b11);
    start_seq("zero");
    @(negedge clk);
    #1;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_wr", 32'(aud.write_audio_out), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("zero_done_pulse", 32'(done), 32'd0);
    enable = 1'b0;

    // Continuous, stopped by enable low
    cfg(12'd1, 24'd5, 20'd3, 20'd2, 8'd0, 2'b11);
    for (int i = 0; i < 51; i++) begin
      exp_l[i] = cont_pat[i % 5];
      exp_r[i] = cont_pat[i % 5];
    end
    start_seq("cont");
    collect("cont", 50, 1'b0, 80);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    #1;
    chk("cont_last_wr", 32'(aud.write_audio_out), 32'd1);
    chk("cont_last_l", aud.left_channel_audio_out, exp_l[50]);
    @(negedge clk);
    #1;
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_done", 32'(done), 32'd0);
    chk("cont_stop_wr", 32'(aud.write_audio_out), 32'd0);
    @(negedge clk);
    #1;
    chk("cont_no_done", 32'(done), 32'd0);

    // Reset mid-ON, then wait for a fresh enable edge
    cfg(12'd2, 24'd100, 20'd8, 20'd4, 8'd1, 2'b11);
    for (int i = 0; i < 12; i++) begin
      exp_l[i] = step_pat[i];
      exp_r[i] = step_pat[i];
    end
    start_seq("rst");
    collect("rst_pre", 3, 1'b0, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_l", aud.left_channel_audio_out, 32'd0);
    chk("rst_mid_r", aud.right_channel_audio_out, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_wr", 32'(aud.write_audio_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_busy", 32'(busy), 32'd0);
      chk("rst_hold_wr", 32'(aud.write_audio_out), 32'd0);
    end
    enable = 1'b0;
    start_seq("restart");
    collect("restart", 12, 1'b0, 40);
    expect_done("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Parametrised alarm tone source. It produces a stereo square-wave beep with programmable pitch, amplitude and on/off cadence, plus a bounded or continuous repeat count. Samples are pushed into the Audio_Controller DAC FIFO through its write handshake (left/right sample, write strobe, `audio_out_allowed`). It supersedes the fixed-tone alarm: pitch and cadence are counted in accepted samples rather than clocks, so they are independent of `CLOCK_50`.

## Interface
- `SAMPLE_W`, 32: audio sample width, two's complement.
- `AMP_W`, 24: amplitude field width; requires `AMP_W <= SAMPLE_W-1`.
- `HP_W`, 12: tone half-period counter width, in samples.
- `CAD_W`, 20: on/off cadence length width, in samples.
- `REP_W`, 8: repeat-count width.

- `CLOCK_50` in 1: system clock. All logic is on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level. A rising edge starts a sequence; low stops it.
- `half_period` in HP_W: tone half-period in samples. 0 is treated as 1.
- `amplitude` in AMP_W: peak magnitude, unsigned.
- `on_len` in CAD_W: beep length in samples. 0 means the tone is never on.
- `off_len` in CAD_W: silence length in samples. 0 means no gap.
- `repeats` in REP_W: number of on+off cycles. 0 means continuous.
- `chan_en` in 2: bit0 enables left, bit1 enables right. A disabled channel outputs 0.
- `audio_out_allowed` in 1: FIFO has space (from Audio_Controller).
- `write_audio_out` out 1: sample write strobe.
- `left_channel_audio_out` out SAMPLE_W: left sample.
- `right_channel_audio_out` out SAMPLE_W: right sample.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a bounded sequence completes.

## Operation
- States: IDLE, ON, OFF.
- IDLE → ON on an `enable` rising edge (previous-cycle `enable` register).
  - On that edge, latch all configuration inputs. Configuration changes mid-sequence are ignored.
  - Clear the phase, cadence and repeat counters. Set the polarity register to positive.
  - If latched `on_len`==0, enter OFF directly.
- Accepted sample = `write_audio_out & audio_out_allowed`. All counters advance only on accepted samples.
- ON:
  - Sample = polarity ? +amplitude : −amplitude, sign-extended to SAMPLE_W.
  - The phase counter counts to half_period−1, then wraps to 0 and toggles polarity.
  - When the cadence counter reaches on_len−1 on an accepted sample, go to OFF, or to the repeat check if off_len==0.
- OFF:
  - Sample = 0. The phase counter is held at 0 and polarity is reset to positive, so every beep starts on the positive half.
  - When the cadence counter reaches off_len−1, run the repeat check.
- Repeat check:
  - Increment the repeat counter.
  - If repeats≠0 and the counter equals repeats: go to IDLE and pulse `done`.
  - Otherwise go to ON (or OFF if on_len==0).
- Degenerate case: on_len==0 and off_len==0 goes straight to IDLE with `done` after a single repeat check. No samples are written.
- `enable` low in ON or OFF: return to IDLE on the next edge with no `done` pulse. A sample accepted in that same cycle is the last one.
- Both `enable` edges in one cycle are impossible (level sampled). Re-raising `enable` in IDLE restarts with fresh config.

## Timing
- Reset values: state IDLE, all counters 0, polarity positive. `write_audio_out`=0, both sample outputs 0, `busy`=0, `done`=0.
- `write_audio_out` = (state≠IDLE) & `audio_out_allowed`. It is combinational on the allowed input, so a sample is accepted in the same cycle.
- Sample outputs are registered and updated on each accepted sample. The value presented is always the one for the current counter state.
- Start latency: the `enable` rising edge is registered at edge N. ON is entered at edge N+1. The first write is possible in cycle N+1.
- `audio_out_allowed` low stalls the block: counters, outputs and state hold indefinitely.
- `done` is asserted the cycle after the final accepted sample, for exactly 1 cycle. `busy` falls at the same edge.
- Reset assertion mid-sequence drops all outputs to reset values immediately (asynchronous).

## Structure
- Package `alarm_pkg`:
  - state enum {IDLE, ON, OFF}.
  - The `sample_t` width function.
  - Constant `CH_LEFT`=0, `CH_RIGHT`=1.
- Sub-module `sq_osc`: phase counter, polarity register and signed amplitude output. Advances on an `adv` input; `clr` forces phase 0 and positive polarity.
- The top level holds the FSM, cadence counter, repeat counter, config latches and channel masking.

## Test plan
- Stepping: half_period=2, amplitude=100, on_len=8, off_len=4, repeats=1, `audio_out_allowed` tied high.
  - Samples: +100,+100,−100,−100,+100,+100,−100,−100, then 0×4.
  - `done` pulses after the 12th write; `busy` falls.
- Stall: same config with `audio_out_allowed` toggled 1/0 every cycle. The sample sequence is identical, each sample written only while allowed, and the total is still 12 writes.
- Continuous: repeats=0, on_len=3, off_len=2. After 50 accepted samples `enable` drops. The block returns to IDLE the next cycle with no `done`; samples follow the period-5 pattern.
- Channel mask and sign extension: `chan_en`=2'b10, amplitude=24'h7FFFFF.
  - Left is always 0.
  - Right = 32'h007FFFFF / 32'hFF800001.
- Degenerate config: half_period=0 toggles polarity every sample; on_len=0, off_len=0 writes no samples and gives `done` 1 cycle after start.
- Reset mid-ON (`resetn` low between edges): outputs are 0 immediately. After release the block waits in IDLE until a new `enable` rising edge.
